rank_template_render: RTL and testbench
=======================================

# rank_template_render

Renders a stored 1-bit rank template onto the video raster at a card's corner position, the read-out counterpart of the rank-matching path that captures the corner mask into memory. A template of corner_width × rank_height bits is loaded through a valid/ready stream, then replayed pixel-by-pixel inside the rank window every frame, two cycles behind the scan coordinates. Output feeds the video mixer as a debug/overlay layer and the template-authoring path.

## Interface
- corner_width, 28, template columns
- rank_height, 40, template rows
- clk  in  1  system clock; everything in this block is clocked on its rising edge
- rst  in  1  reset, asynchronous and active-low
- hcount  in  11  raster column
- vcount  in  10  raster row
- left_edge  in  11  card left edge; sampled at frame start
- top_edge  in  10  card top edge; sampled at frame start
- load_start  in  1  pulse: begin or restart a template load
- load_valid  in  1  load beat valid
- load_data  in  1  template bit, row-major, row 0 column 0 first
- load_ready  out  1  beat accepted when load_valid && load_ready
- load_done  out  1  one-cycle pulse after final beat accepted
- hcount_out  out  11  hcount delayed 2 cycles
- vcount_out  out  10  vcount delayed 2 cycles
- in_window_out  out  1  delayed in-window flag
- pixel_out  out  1  template bit; 0 outside window or when no template is loaded

## Operation
- RANK_SIZE = corner_width*rank_height (1120); ADDR_W = $clog2(RANK_SIZE) (11).
- States: EMPTY (reset), LOAD, RUN.
  - EMPTY: load_ready=0; pixel_out=0; load_start → LOAD.
  - LOAD: load_ready=1; each accepted beat writes wr_addr, wr_addr+1.
    - Beat at wr_addr==RANK_SIZE-1 → RUN, load_done=1 next cycle, wr_addr=0.
    - load_start in LOAD restarts at wr_addr=0.
  - RUN: load_ready=0; load_start → LOAD (wr_addr=0), template rendering stops immediately.
- load_start and final beat in same cycle: load_start wins. Beat is not counted, no load_done, wr_addr=0.
- Frame start is hcount==0 && vcount==0. At frame start:
  - latch L=left_edge and T=top_edge;
  - clear rd_addr to 0.
- Window: hcount in [L+5, L+4+corner_width] and vcount in [T+1, T+rank_height]. This is exactly RANK_SIZE pixels per frame if fully on-raster.
- rd_addr increments on each in-window pixel and saturates at RANK_SIZE-1. Off-raster clipping shortens readout; nothing wraps.
- Edge arithmetic is done at 12 bits, so L+4+corner_width does not overflow 11 bits.
- pixel_out = RAM bit && delayed in_window && state was RUN at read issue.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=EMPTY, wr_addr=rd_addr=0, L=T=0;
  - all outputs 0, including the delay pipeline.
- Latency: hcount/vcount → *_out, in_window_out, pixel_out is exactly 2 cycles, matching RAM read latency. No bubbles.
- Load throughput: 1 beat/cycle; load_ready is combinational from state only, never from load_valid.
- RAM writes occur only in LOAD. Reads are ignored unless RUN, so there is no read/write collision.
- Reset mid-load → EMPTY. RAM contents are treated as invalid; a full reload is required.
- Edge inputs changing mid-frame have no effect until the next frame start.

## Structure
- Package rank_pkg holds:
  - CORNER_WIDTH, RANK_HEIGHT, RANK_SIZE, ADDR_W;
  - RAM_LATENCY=2;
  - typedef enum {EMPTY, LOAD, RUN} render_state_t.
- Template storage is one instance of xilinx_true_dual_port_read_first_2_clock_ram (width 1, depth RANK_SIZE, both ports on clk): port A writes, port B reads.
- Window compare, counters, FSM and the 2-stage coordinate/flag pipeline are local.

## Test plan
- Reset then idle raster: all outputs 0; load_ready=0; pixel_out=0 across a full 800×525 frame.
- Load checkerboard (bit = (row+col)&1) with load_valid held high:
  - 1120 beats accepted;
  - load_done pulses once, the cycle after beat 1120;
  - load_ready drops.
- Render with left_edge=100, top_edge=50:
  - in_window_out high for hcount_out 105..132 and vcount_out 51..90;
  - pixel_out matches checkerboard;
  - 1120 window pixels total.
- Stall load with load_valid toggling 1/0:
  - 2240 cycles to complete;
  - RAM contents identical to the back-to-back load.
- load_start on beat 1120: no load_done; reload of 1120 new beats required.
- Assert rst at beat 500, release, raster frame: pixel_out=0 everywhere and state EMPTY. Change left_edge mid-frame: window moves only on the next frame.

Source files
------------

// File: rtl/rank_pkg.sv
// Shared sizes and state encoding for the rank template renderer.
package rank_pkg;

  localparam int unsigned CORNER_WIDTH = 28;
  localparam int unsigned RANK_HEIGHT  = 40;
  localparam int unsigned RANK_SIZE    = CORNER_WIDTH * RANK_HEIGHT;
  localparam int unsigned ADDR_W       = $clog2(RANK_SIZE);
  localparam int unsigned RAM_LATENCY  = 2;
  localparam int unsigned H_W          = 11;
  localparam int unsigned V_W          = 10;
  localparam int unsigned EDGE_W       = 12;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } render_state_t;

endpackage

// File: rtl/rank_template_render_if.sv
// Raster, template-load stream and overlay output bundle for rank_template_render.
interface rank_template_render_if;
  import rank_pkg::*;

  logic [H_W-1:0] hcount;
  logic [V_W-1:0] vcount;
  logic [H_W-1:0] left_edge;
  logic [V_W-1:0] top_edge;
  logic           load_start;
  logic           load_valid;
  logic           load_data;
  logic           load_ready;
  logic           load_done;
  logic [H_W-1:0] hcount_out;
  logic [V_W-1:0] vcount_out;
  logic           in_window_out;
  logic           pixel_out;

  modport master (
    output hcount, vcount, left_edge, top_edge, load_start, load_valid, load_data,
    input  load_ready, load_done, hcount_out, vcount_out, in_window_out, pixel_out
  );

  modport slave (
    input  hcount, vcount, left_edge, top_edge, load_start, load_valid, load_data,
    output load_ready, load_done, hcount_out, vcount_out, in_window_out, pixel_out
  );

endinterface

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Block-RAM template: port A read/write, port B read, read-first, with output registers
// (two-cycle read latency). Port B's synchronous reset clears its output register.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int unsigned RAM_WIDTH = 1,
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic                         clka,
  input  logic                         clkb,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         wea,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_a;
  logic [RAM_WIDTH-1:0] ram_b;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_a <= mem[addra];
    end
  end

  always_ff @(posedge clka) begin
    if (rsta)        douta <= '0;
    else if (regcea) douta <= ram_a;
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_b <= mem[addrb];
  end

  always_ff @(posedge clkb) begin
    if (rstb)        doutb <= '0;
    else if (regceb) doutb <= ram_b;
  end

endmodule

// File: rtl/rank_template_render.sv
// Loads a 1-bit rank template over a valid/ready stream and replays it inside the
// per-frame rank window, two cycles behind the raster coordinates.
module rank_template_render
  import rank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rank_template_render_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RANK_SIZE - 1);

  render_state_t     state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              load_done_q;
  logic [H_W-1:0]    left_q;
  logic [V_W-1:0]    top_q;

  logic [H_W-1:0]    hcount_d1, hcount_q;
  logic [V_W-1:0]    vcount_d1, vcount_q;
  logic              win_d1, win_q, run_d1;

  logic              wr_en_c, frame_start_c, in_window_c, blank_c;
  logic              pixel_c, ram_a_unused;
  logic [EDGE_W-1:0] h_ext, v_ext, l_ext, t_ext;

  assign bus.load_ready = (state == LOAD);
  assign wr_en_c        = (state == LOAD) && bus.load_valid && !bus.load_start;
  assign frame_start_c  = (bus.hcount == '0) && (bus.vcount == '0);

  // Window bounds widened to 12 bits so the right/bottom edges cannot wrap.
  assign h_ext = EDGE_W'(bus.hcount);
  assign v_ext = EDGE_W'(bus.vcount);
  assign l_ext = EDGE_W'(left_q);
  assign t_ext = EDGE_W'(top_q);
  assign in_window_c = (h_ext >= l_ext + EDGE_W'(5)) &&
                       (h_ext <= l_ext + EDGE_W'(4 + CORNER_WIDTH)) &&
                       (v_ext >= t_ext + EDGE_W'(1)) &&
                       (v_ext <= t_ext + EDGE_W'(RANK_HEIGHT));

  // Load/render control; load_start takes priority over a coincident final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      wr_addr     <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state)
        EMPTY: begin
          if (bus.load_start) begin
            state   <= LOAD;
            wr_addr <= '0;
          end
        end
        LOAD: begin
          if (bus.load_start) begin
            wr_addr <= '0;
          end else if (bus.load_valid) begin
            if (wr_addr == LAST_ADDR) begin
              state       <= RUN;
              wr_addr     <= '0;
              load_done_q <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        RUN: begin
          if (bus.load_start) begin
            state   <= LOAD;
            wr_addr <= '0;
          end
        end
        default: begin
          state   <= EMPTY;
          wr_addr <= '0;
        end
      endcase
    end
  end

  // Frame-start edge latch and saturating read pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q  <= '0;
      top_q   <= '0;
      rd_addr <= '0;
    end else if (frame_start_c) begin
      left_q  <= bus.left_edge;
      top_q   <= bus.top_edge;
      rd_addr <= '0;
    end else if (in_window_c && (rd_addr != LAST_ADDR)) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  // Coordinate/flag pipeline matched to the RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      win_d1    <= 1'b0;
      run_d1    <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      win_q     <= 1'b0;
    end else begin
      hcount_d1 <= bus.hcount;
      vcount_d1 <= bus.vcount;
      win_d1    <= in_window_c;
      run_d1    <= (state == RUN);
      hcount_q  <= hcount_d1;
      vcount_q  <= vcount_d1;
      win_q     <= win_d1;
    end
  end

  // The RAM output register doubles as the pixel register; blanking clears it.
  assign blank_c = !(win_d1 && run_d1);

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH (1),
    .RAM_DEPTH (RANK_SIZE)
  ) u_ram (
    .clka   (clk),
    .clkb   (clk),
    .ena    (wr_en_c),
    .enb    (1'b1),
    .wea    (wr_en_c),
    .rsta   (1'b0),
    .rstb   (blank_c),
    .regcea (1'b0),
    .regceb (1'b1),
    .addra  (wr_addr),
    .addrb  (rd_addr),
    .dina   (bus.load_data),
    .douta  (ram_a_unused),
    .doutb  (pixel_c)
  );

  assign bus.load_done     = load_done_q;
  assign bus.hcount_out    = hcount_q;
  assign bus.vcount_out    = vcount_q;
  assign bus.in_window_out = win_q;
  assign bus.pixel_out     = pixel_c;

endmodule

// File: tb/tb_rank_template_render.sv
// Directed bench for rank_template_render: template loads, rendered frames, reset and edge latching.
module tb_rank_template_render;
  import rank_pkg::*;

  localparam int CW = int'(CORNER_WIDTH);
  localparam int RH = int'(RANK_HEIGHT);
  localparam int RS = int'(RANK_SIZE);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rank_template_render_if bus();

  rank_template_render u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        w;
    logic        p;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int d_h = 2047, d_v = 1023, d_left = 0, d_top = 0;
  bit d_start = 1'b0, d_valid = 1'b0, d_data = 1'b0, d_rst = 1'b0;

  int m_left = 0, m_top = 0, m_pat = 0;
  bit m_run = 1'b0;

  int win_cnt, pix_cnt, pix_err, done_cnt;
  int hmin, hmax, vmin, vmax;
  bit s_done;

  function automatic bit tbit(input int pat, input int idx);
    int r, c;
    r = idx / CW;
    c = idx % CW;
    case (pat)
      0:       return ((r + c) % 2) == 1;
      1:       return ((r + c) % 2) == 0;
      default: return ((r * 7 + c * 3) % 5) == 0;
    endcase
  endfunction

  function automatic int ones(input int pat);
    int n = 0;
    for (int i = 0; i < RS; i++) if (tbit(pat, i)) n++;
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // One clock: sample outputs against the model from two cycles ago, then drive.
  task automatic step();
    exp_t e;
    int   lo, hi;
    bit   w;
    @(negedge clk);
    s_done = bus.load_done;
    if (s_done) done_cnt++;
    if (q.size() == 2) begin
      e = q.pop_front();
      if (bus.hcount_out !== e.h || bus.vcount_out !== e.v ||
          bus.in_window_out !== e.w || bus.pixel_out !== e.p) pix_err++;
      if (bus.in_window_out) begin
        win_cnt++;
        if (int'(bus.hcount_out) < hmin) hmin = int'(bus.hcount_out);
        if (int'(bus.hcount_out) > hmax) hmax = int'(bus.hcount_out);
        if (int'(bus.vcount_out) < vmin) vmin = int'(bus.vcount_out);
        if (int'(bus.vcount_out) > vmax) vmax = int'(bus.vcount_out);
      end
      if (bus.pixel_out) pix_cnt++;
    end
    rst            = d_rst;
    bus.hcount     = 11'(d_h);
    bus.vcount     = 10'(d_v);
    bus.left_edge  = 11'(d_left);
    bus.top_edge   = 10'(d_top);
    bus.load_start = d_start;
    bus.load_valid = d_valid;
    bus.load_data  = d_data;
    if (!d_rst) begin
      q.delete();
    end else begin
      lo  = m_left + 5;
      hi  = m_left + 4 + CW;
      w   = (d_h >= lo) && (d_h <= hi) && (d_v >= m_top + 1) && (d_v <= m_top + RH);
      e.h = 11'(d_h);
      e.v = 10'(d_v);
      e.w = w;
      e.p = w ? (m_run && tbit(m_pat, (d_v - m_top - 1) * CW + (d_h - lo))) : 1'b0;
      q.push_back(e);
      if (d_h == 0 && d_v == 0) begin
        m_left = d_left;
        m_top  = d_top;
      end
    end
  endtask

  task automatic frame(input int hn, input int vn, input int chg_row, input int chg_left);
    win_cnt = 0; pix_cnt = 0; pix_err = 0;
    hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
    for (int v = 0; v < vn; v++) begin
      for (int h = 0; h < hn; h++) begin
        if (v == chg_row && h == 0) d_left = chg_left;
        d_h = h;
        d_v = v;
        step();
      end
    end
    d_h = 2047;
    d_v = 1023;
    step();
    step();
  endtask

  task automatic load_tmpl(input string tag, input int pat, input bit issue_start,
                           input bit stall, input bit collide, input int exp_cyc);
    int beats = 0;
    int cyc   = 0;
    done_cnt = 0;
    if (issue_start) begin
      d_start = 1'b1; d_valid = 1'b0;
      step();
      d_start = 1'b0;
      m_run   = 1'b0;
    end
    while (beats < RS && cyc < 6000) begin
      d_valid = stall ? (cyc % 2 == 0) : 1'b1;
      d_data  = tbit(pat, beats);
      d_start = collide && (beats == RS - 1);
      step();
      cyc++;
      if (d_valid && bus.load_ready) beats++;
    end
    check({tag, "_beats"}, beats, RS);
    d_start = 1'b0;
    d_valid = 1'b0;
    step();
    if (collide) begin
      check({tag, "_no_done"}, int'(s_done), 0);
      check({tag, "_still_loading"}, int'(bus.load_ready), 1);
      check({tag, "_done_cnt"}, done_cnt, 0);
    end else begin
      check({tag, "_done_pulse"}, int'(s_done), 1);
      check({tag, "_ready_low"}, int'(bus.load_ready), 0);
      check({tag, "_cycles"}, cyc + 1, exp_cyc);
      step();
      check({tag, "_done_single"}, done_cnt, 1);
      m_pat = pat;
      m_run = 1'b1;
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.hcount     = 11'h7ff;
    bus.vcount     = 10'h3ff;
    bus.left_edge  = '0;
    bus.top_edge   = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 1'b0;

    repeat (3) step();
    check("reset_hcount_out", int'(bus.hcount_out), 0);
    check("reset_vcount_out", int'(bus.vcount_out), 0);
    check("reset_in_window", int'(bus.in_window_out), 0);
    check("reset_pixel", int'(bus.pixel_out), 0);
    check("reset_ready", int'(bus.load_ready), 0);
    check("reset_done", int'(bus.load_done), 0);
    d_rst = 1'b1;
    step();

    // Idle raster with no template: window tracks, pixels stay dark.
    d_left = 100; d_top = 50;
    frame(136, 92, -1, 0);
    check("idle_win", win_cnt, 1120);
    check("idle_pix", pix_cnt, 0);
    check("idle_err", pix_err, 0);
    check("idle_ready", int'(bus.load_ready), 0);

    load_tmpl("b2b", 0, 1'b1, 1'b0, 1'b0, 1121);
    frame(136, 92, -1, 0);
    check("r0_win", win_cnt, 1120);
    check("r0_pix", pix_cnt, 560);
    check("r0_err", pix_err, 0);
    check("r0_hmin", hmin, 105);
    check("r0_hmax", hmax, 132);
    check("r0_vmin", vmin, 51);
    check("r0_vmax", vmax, 90);

    // load_start coinciding with the final beat forces a full reload.
    load_tmpl("collide", 1, 1'b1, 1'b0, 1'b1, 0);
    load_tmpl("reload", 2, 1'b0, 1'b0, 1'b0, 1121);
    frame(136, 92, -1, 0);
    check("r2_win", win_cnt, 1120);
    check("r2_pix", pix_cnt, ones(2));
    check("r2_err", pix_err, 0);

    load_tmpl("stall", 0, 1'b1, 1'b1, 1'b0, 2240);
    frame(136, 92, -1, 0);
    check("rs_win", win_cnt, 1120);
    check("rs_pix", pix_cnt, 560);
    check("rs_err", pix_err, 0);

    // Reset in the middle of a load.
    done_cnt = 0;
    d_start = 1'b1; step(); d_start = 1'b0;
    m_run = 1'b0;
    d_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      d_data = tbit(1, i);
      step();
    end
    d_valid = 1'b0;
    d_rst   = 1'b0;
    repeat (3) step();
    check("mrst_hcount_out", int'(bus.hcount_out), 0);
    check("mrst_in_window", int'(bus.in_window_out), 0);
    check("mrst_pixel", int'(bus.pixel_out), 0);
    check("mrst_ready", int'(bus.load_ready), 0);
    d_rst = 1'b1;
    step();
    d_valid = 1'b1;
    repeat (4) step();
    d_valid = 1'b0;
    check("mrst_empty_ready", int'(bus.load_ready), 0);
    check("mrst_no_done", done_cnt, 0);

    d_left = 10; d_top = 5;
    frame(50, 50, -1, 0);
    check("post_rst_win", win_cnt, 1120);
    check("post_rst_pix", pix_cnt, 0);
    check("post_rst_err", pix_err, 0);

    // left_edge moves mid-frame: window holds until the next frame start.
    frame(50, 50, 25, 20);
    check("chg_same_win", win_cnt, 1120);
    check("chg_same_hmin", hmin, 15);
    check("chg_same_err", pix_err, 0);
    frame(50, 50, -1, 0);
    check("chg_next_win", win_cnt, 1000);
    check("chg_next_hmin", hmin, 25);
    check("chg_next_hmax", hmax, 49);
    check("chg_next_err", pix_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
